ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port front end for a single-port synchronous RAM.
// Requesters A and B each hold a request until their one-cycle ACK. Each
// transaction runs IDLE -> ACCESS -> DONE. A tie goes to the requester
// that was not served last.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no transaction; arbitrate and latch the winner's command
//   ACCESS | RAM_EN high for one cycle with the latched command
//   DONE   | ACK to the granted requester; read data shown on DOUT
module ram_arbiter #(
    parameter int DW = 10,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_A,
    input  logic          WE_A,
    input  logic [AW-1:0] ADDR_A,
    input  logic [DW-1:0] DIN_A,
    input  logic          REQ_B,
    input  logic          WE_B,
    input  logic [AW-1:0] ADDR_B,
    input  logic [DW-1:0] DIN_B,
    output logic          ACK_A,
    output logic          ACK_B,
    output logic [DW-1:0] DOUT,
    output logic          BUSY,
    output logic          RAM_EN,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DIN,
    input  logic [DW-1:0] RAM_DOUT
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic          last_b;    // 1: B was granted most recently
    logic          gnt_b;     // owner of the transaction in flight
    logic          rd_q;      // transaction in flight is a read
    logic [DW-1:0] dout_q;    // last read data, held across writes
    logic          pick_b;

    // Pick a winner among the current requests; a tie goes to the requester not served last
    always_comb begin
        pick_b = 1'b0;
        if (REQ_A && REQ_B) begin
            pick_b = ~last_b;
        end else if (REQ_B) begin
            pick_b = 1'b1;
        end
    end

    // Sequencer: grant and latch in IDLE, drive the RAM in ACCESS, acknowledge in DONE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            gnt_b    <= 1'b0;
            rd_q     <= 1'b0;
            dout_q   <= '0;
            ACK_A    <= 1'b0;
            ACK_B    <= 1'b0;
            BUSY     <= 1'b0;
            RAM_EN   <= 1'b0;
            RAM_WE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DIN  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_A || REQ_B) begin
                        state    <= ACCESS;
                        BUSY     <= 1'b1;
                        RAM_EN   <= 1'b1;
                        gnt_b    <= pick_b;
                        last_b   <= pick_b;
                        RAM_WE   <= pick_b ? WE_B : WE_A;
                        rd_q     <= pick_b ? ~WE_B : ~WE_A;
                        RAM_ADDR <= pick_b ? ADDR_B : ADDR_A;
                        RAM_DIN  <= pick_b ? DIN_B : DIN_A;
                    end
                end
                ACCESS: begin
                    state  <= DONE;
                    RAM_EN <= 1'b0;
                    RAM_WE <= 1'b0;
                    ACK_A  <= ~gnt_b;
                    ACK_B  <= gnt_b;
                end
                DONE: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    ACK_A <= 1'b0;
                    ACK_B <= 1'b0;
                    if (rd_q) begin
                        dout_q <= RAM_DOUT;
                    end
                end
                default: begin
                    state  <= IDLE;
                    BUSY   <= 1'b0;
                    ACK_A  <= 1'b0;
                    ACK_B  <= 1'b0;
                    RAM_EN <= 1'b0;
                    RAM_WE <= 1'b0;
                end
            endcase
        end
    end

    // The RAM returns read data only in the DONE cycle, so it goes straight to DOUT there; otherwise the held copy is shown
    always_comb begin
        DOUT = dout_q;
        if (state == DONE && rd_q) begin
            DOUT = RAM_DOUT;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, hand-written
// corner sequences, then random requesters against a transaction-level model.
module tb_ram_arbiter;
    localparam int DW = 10;
    localparam int AW = 8;
    localparam int NCYC = 600;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_A, WE_A, REQ_B, WE_B;
    logic [AW-1:0] ADDR_A, ADDR_B;
    logic [DW-1:0] DIN_A, DIN_B;
    logic          ACK_A, ACK_B, BUSY, RAM_EN, RAM_WE;
    logic [DW-1:0] DOUT, RAM_DIN;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DOUT = '0;

    logic [DW-1:0] mem [256] = '{default: '0};

    int checks = 0;
    int failures = 0;

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .DIN_A(DIN_A),
        .REQ_B(REQ_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .DIN_B(DIN_B),
        .ACK_A(ACK_A), .ACK_B(ACK_B), .DOUT(DOUT), .BUSY(BUSY),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM: read data appears the cycle after the enable
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
            else        RAM_DOUT <= mem[RAM_ADDR];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          ra, wa;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          rb, wb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          acka, ackb, en, we, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] din, dout;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ra, input logic wa, input int aa, input int da,
                                input logic rb, input logic wb, input int ab, input int db,
                                input logic acka, input logic ackb, input logic en, input logic we,
                                input logic busy, input int addr, input int din, input int dout);
        vec_t v;
        v.rst = rst; v.ra = ra; v.wa = wa; v.aa = AW'(aa); v.da = DW'(da);
        v.rb = rb; v.wb = wb; v.ab = AW'(ab); v.db = DW'(db);
        v.acka = acka; v.ackb = ackb; v.en = en; v.we = we; v.busy = busy;
        v.addr = AW'(addr); v.din = DW'(din); v.dout = DW'(dout);
        return v;
    endfunction

    task automatic idle_inputs();
        REQ_A = 0; WE_A = 0; ADDR_A = '0; DIN_A = '0;
        REQ_B = 0; WE_B = 0; ADDR_B = '0; DIN_B = '0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1;
        REQ_A = 1'($urandom); WE_A = 1'($urandom); ADDR_A = AW'($urandom); DIN_A = DW'($urandom);
        REQ_B = 1'($urandom); WE_B = 1'($urandom); ADDR_B = AW'($urandom); DIN_B = DW'($urandom);
        @(posedge CLK); #1;
        RST = 0;
        idle_inputs();
    endtask

    // random-phase model state
    logic          e_acka [NCYC+4];
    logic          e_ackb [NCYC+4];
    logic          e_en   [NCYC+4];
    logic          e_we   [NCYC+4];
    logic          e_busy [NCYC+4];
    logic [AW-1:0] e_addr [NCYC+4];
    logic [DW-1:0] e_din  [NCYC+4];
    logic          e_dset [NCYC+4];
    logic [DW-1:0] e_dval [NCYC+4];
    logic [DW-1:0] model_mem [256];

    vec_t tbl [15];

    initial begin
        int en_cnt;
        int ack_who [$];
        logic [DW-1:0] ack_dat [$];
        int next_free, last_win;
        logic [DW-1:0] dmodel;
        logic a_busy, b_busy;

        RST = 1;
        idle_inputs();

        tbl[0]  = mk(0, 1,1,0,29, 0,0,0,0,  0,0,0,0,0, 0,0,0);
        tbl[1]  = mk(0, 1,1,0,29, 0,0,0,0,  0,0,1,1,1, 0,29,0);
        tbl[2]  = mk(0, 1,1,0,29, 0,0,0,0,  1,0,0,0,1, 0,0,0);
        tbl[3]  = mk(0, 1,0,0,0,  0,0,0,0,  0,0,0,0,0, 0,0,0);
        tbl[4]  = mk(0, 1,0,0,0,  0,0,0,0,  0,0,1,0,1, 0,0,0);
        tbl[5]  = mk(0, 1,0,0,0,  0,0,0,0,  1,0,0,0,1, 0,0,29);
        tbl[6]  = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0, 0,0,29);
        tbl[7]  = mk(1, 1,1,5,7,  1,0,9,3,  0,0,0,0,0, 0,0,29);
        tbl[8]  = mk(0, 1,1,1,45, 1,0,1,0,  0,0,0,0,0, 0,0,0);
        tbl[9]  = mk(0, 1,1,1,45, 1,0,1,0,  0,0,1,1,1, 1,45,0);
        tbl[10] = mk(0, 1,1,1,45, 1,0,1,0,  1,0,0,0,1, 0,0,0);
        tbl[11] = mk(0, 0,0,0,0,  1,0,1,0,  0,0,0,0,0, 0,0,0);
        tbl[12] = mk(0, 0,0,0,0,  1,0,1,0,  0,0,1,0,1, 1,0,0);
        tbl[13] = mk(0, 0,0,0,0,  1,0,1,0,  0,1,0,0,1, 0,0,45);
        tbl[14] = mk(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0, 0,0,45);

        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 15; i++) begin
            RST = tbl[i].rst;
            REQ_A = tbl[i].ra; WE_A = tbl[i].wa; ADDR_A = tbl[i].aa; DIN_A = tbl[i].da;
            REQ_B = tbl[i].rb; WE_B = tbl[i].wb; ADDR_B = tbl[i].ab; DIN_B = tbl[i].db;
            @(negedge CLK);
            chk($sformatf("tbl%0d ack_a", i), 32'(ACK_A), 32'(tbl[i].acka));
            chk($sformatf("tbl%0d ack_b", i), 32'(ACK_B), 32'(tbl[i].ackb));
            chk($sformatf("tbl%0d ram_en", i), 32'(RAM_EN), 32'(tbl[i].en));
            chk($sformatf("tbl%0d busy", i), 32'(BUSY), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d dout", i), 32'(DOUT), 32'(tbl[i].dout));
            if (tbl[i].en) begin
                chk($sformatf("tbl%0d ram_we", i), 32'(RAM_WE), 32'(tbl[i].we));
                chk($sformatf("tbl%0d ram_addr", i), 32'(RAM_ADDR), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d ram_din", i), 32'(RAM_DIN), 32'(tbl[i].din));
            end
            if (i == 8) begin
                chk("post_reset ram_addr", 32'(RAM_ADDR), 0);
                chk("post_reset ram_din", 32'(RAM_DIN), 0);
                chk("post_reset ram_we", 32'(RAM_WE), 0);
            end
            @(posedge CLK); #1;
        end
        idle_inputs();

        // both requesters held for four transactions: grants alternate
        do_reset();
        REQ_A = 1; WE_A = 0; ADDR_A = 0;
        REQ_B = 1; WE_B = 0; ADDR_B = 1;
        en_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (RAM_EN) en_cnt++;
            if (ACK_A) begin ack_who.push_back(0); ack_dat.push_back(DOUT); end
            if (ACK_B) begin ack_who.push_back(1); ack_dat.push_back(DOUT); end
            @(posedge CLK); #1;
        end
        idle_inputs();
        chk("alt ram_en cycles", 32'(en_cnt), 4);
        chk("alt ack count", 32'(ack_who.size()), 4);
        for (int k = 0; k < 4 && k < ack_who.size(); k++) begin
            chk($sformatf("alt grant%0d", k), 32'(ack_who[k]), 32'(k % 2));
            chk($sformatf("alt dout%0d", k), 32'(ack_dat[k]), (k % 2 == 0) ? 29 : 45);
        end

        // reset during ACCESS aborts; next tie goes to A
        do_reset();
        REQ_A = 1; WE_A = 0; ADDR_A = 3;
        @(negedge CLK);
        chk("abort idle ram_en", 32'(RAM_EN), 0);
        @(posedge CLK); #1;
        RST = 1;
        @(negedge CLK);
        chk("abort access ram_en", 32'(RAM_EN), 1);
        @(posedge CLK); #1;
        RST = 0;
        REQ_B = 1; WE_B = 0; ADDR_B = 4;
        @(negedge CLK);
        chk("abort ack_a", 32'(ACK_A), 0);
        chk("abort busy", 32'(BUSY), 0);
        chk("abort ram_en", 32'(RAM_EN), 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort regrant ram_en", 32'(RAM_EN), 1);
        chk("abort regrant addr", 32'(RAM_ADDR), 3);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort regrant ack_a", 32'(ACK_A), 1);
        chk("abort regrant ack_b", 32'(ACK_B), 0);
        @(posedge CLK); #1;
        idle_inputs();

        // random phase against a transaction-level model
        for (int k = 0; k < 256; k++) model_mem[k] = '0;
        model_mem[0] = 29;
        model_mem[1] = 45;
        for (int k = 0; k < NCYC + 4; k++) begin
            e_acka[k] = 0; e_ackb[k] = 0; e_en[k] = 0; e_we[k] = 0; e_busy[k] = 0;
            e_addr[k] = '0; e_din[k] = '0; e_dset[k] = 0; e_dval[k] = '0;
        end
        next_free = 0;
        last_win = 1;
        dmodel = '0;
        a_busy = 0;
        b_busy = 0;
        do_reset();
        for (int t = 0; t < NCYC; t++) begin
            @(negedge CLK);
            if (e_dset[t]) dmodel = e_dval[t];
            chk($sformatf("rnd t%0d ack_a", t), 32'(ACK_A), 32'(e_acka[t]));
            chk($sformatf("rnd t%0d ack_b", t), 32'(ACK_B), 32'(e_ackb[t]));
            chk($sformatf("rnd t%0d ram_en", t), 32'(RAM_EN), 32'(e_en[t]));
            chk($sformatf("rnd t%0d busy", t), 32'(BUSY), 32'(e_busy[t]));
            chk($sformatf("rnd t%0d dout", t), 32'(DOUT), 32'(dmodel));
            if (e_en[t]) begin
                chk($sformatf("rnd t%0d ram_we", t), 32'(RAM_WE), 32'(e_we[t]));
                chk($sformatf("rnd t%0d ram_addr", t), 32'(RAM_ADDR), 32'(e_addr[t]));
                if (e_we[t]) chk($sformatf("rnd t%0d ram_din", t), 32'(RAM_DIN), 32'(e_din[t]));
            end
            if (t >= next_free && (REQ_A || REQ_B)) begin
                int win;
                logic w;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                win = (REQ_A && REQ_B) ? 1 - last_win : (REQ_B ? 1 : 0);
                last_win = win;
                w = win ? WE_B : WE_A;
                a = win ? ADDR_B : ADDR_A;
                d = win ? DIN_B : DIN_A;
                e_en[t+1] = 1; e_we[t+1] = w; e_addr[t+1] = a; e_din[t+1] = d;
                e_busy[t+1] = 1; e_busy[t+2] = 1;
                if (win) begin e_ackb[t+2] = 1; b_busy = 1; end
                else     begin e_acka[t+2] = 1; a_busy = 1; end
                if (w) model_mem[a] = d;
                else begin e_dset[t+2] = 1; e_dval[t+2] = model_mem[a]; end
                next_free = t + 3;
            end
            @(posedge CLK); #1;
            if (e_acka[t]) begin
                a_busy = 0;
                REQ_A = 1'($urandom); WE_A = 1'($urandom); ADDR_A = AW'($urandom % 8); DIN_A = DW'($urandom);
            end else if (a_busy) begin
                WE_A = 1'($urandom); ADDR_A = AW'($urandom % 8); DIN_A = DW'($urandom);
            end else if (!REQ_A && ($urandom % 3 == 0)) begin
                REQ_A = 1; WE_A = 1'($urandom); ADDR_A = AW'($urandom % 8); DIN_A = DW'($urandom);
            end
            if (e_ackb[t]) begin
                b_busy = 0;
                REQ_B = 1'($urandom); WE_B = 1'($urandom); ADDR_B = AW'($urandom % 8); DIN_B = DW'($urandom);
            end else if (b_busy) begin
                WE_B = 1'($urandom); ADDR_B = AW'($urandom % 8); DIN_B = DW'($urandom);
            end else if (!REQ_B && ($urandom % 3 == 0)) begin
                REQ_B = 1; WE_B = 1'($urandom); ADDR_B = AW'($urandom % 8); DIN_B = DW'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
